maxnet_input_loader: RTL
========================

// Module: maxnet_input_loader
// PURPOSE
//  Upstream feeder/sequencer for the 4-neuron Maxnet datapath: accepts a frame of input
//  activations and weights as a stream of words over valid/ready, holds them as flat buses
//  driving the datapath's X/W inputs, pulses start, waits for is_finished, returns res.
//  Replaces the hardwired memory image so new frames can be loaded at run time.
// PARAMETERS
//  DATA_W   32   word width of activations, weights and result
//  N        4    neurons; frame length = N + N*N words (20 by default)
//  SETTLE   2    WAIT cycles during which is_finished is ignored (datapath loading X)
//  TIMEOUT  256  max WAIT cycles before giving up with result_err
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           synchronous reset, active-low
//  in_valid      in   1           upstream word valid
//  in_data       in   DATA_W      upstream word
//  in_ready      out  1           loader accepts a word this cycle
//  x_flat        out  N*DATA_W    activations; word i at [i*DATA_W +: DATA_W]
//  w_flat        out  N*N*DATA_W  weights row-major; word j at [j*DATA_W +: DATA_W]
//  start         out  1           one-cycle pulse: datapath begins a run
//  busy          out  1           high in START and WAIT
//  is_finished   in   1           datapath converged (one nonzero neuron)
//  res           in   DATA_W      datapath selected maximum
//  result_valid  out  1           result available; held until accepted
//  result_data   out  DATA_W      captured res (0 on timeout)
//  result_err    out  1           1 = timeout
//  result_cycles out  16          WAIT cycle index at which the result was taken
//  result_ready  in   1           downstream accepts result
// BEHAVIOUR
//  States LOAD -> START -> WAIT -> HOLD -> LOAD. rst low (sampled on clk): state=LOAD, word
//   counter=0, x_flat=w_flat=0, result_data=0, result_err=0, result_cycles=0, start=0.
//  in_ready = (state==LOAD) & rst; forced 0 while rst low, so no word accepted during reset.
//  LOAD: transfer on in_valid&in_ready; counter c: c<N -> x[c], else w[c-N]; c++.
//   No transfer -> nothing changes. Transfer with c==N+N*N-1 -> START, c=0.
//  START: exactly one cycle; start=1 (registered, asserted in this state only); -> WAIT, wait_cnt=0.
//  WAIT: wait_cnt increments each cycle. is_finished ignored while wait_cnt<SETTLE.
//   wait_cnt>=SETTLE & is_finished: result_data=res, result_err=0, result_cycles=wait_cnt -> HOLD.
//   Else if wait_cnt==TIMEOUT-1: result_data=0, result_err=1, result_cycles=TIMEOUT-1 -> HOLD.
//   Finish and timeout in same cycle: finish wins (err=0).
//  HOLD: result_valid=1; result_* stable until result_valid&result_ready; then -> LOAD.
//   in_ready stays 0 in HOLD; next frame's first word can transfer earliest 1 cycle after
//   the result handshake.
//  x_flat/w_flat change only on LOAD transfers; stable through START/WAIT/HOLD.
//  result_valid/busy are pure decodes of state: 0 after reset.
//  Reset mid-frame or mid-run: abort, counter 0, buses cleared, no start/result emitted.
//  Widths: data is passed through unmodified; wait_cnt 16 bits (TIMEOUT <= 65535).
// TESTING
//  T1 reset: hold rst=0 3 cycles with in_valid=1 -> in_ready=0, start=0, result_valid=0,
//     x_flat=0, w_flat=0; no word captured.
//  T2 back-to-back load of words 1..20 -> x words {1,2,3,4}, w words {5..20}; start=1
//     exactly the cycle after the 20th transfer, one cycle wide; in_ready=0 from then.
//  T3 in_valid toggled 1,0,0,1,... with data changing every cycle -> only valid-cycle words
//     captured, same final image as T2; start after 20th accepted word.
//  T4 stub asserts is_finished at wait_cnt=5 with res=0x0000_0008 -> result_valid=1,
//     result_data=8, err=0, cycles=5; result_ready=0 for 3 cycles -> outputs stable;
//     result_ready=1 -> next cycle state LOAD, in_ready=1.
//  T5 is_finished stuck high from start -> ignored at wait_cnt 0,1; result at cycles=2;
//     TIMEOUT=16 with is_finished=0 -> err=1, data=0, cycles=15.
//  T6 rst=0 after 7 words, then full new frame 101..120 -> x {101..104}, w {105..120}, one start.

Source files
------------

// File: rtl/maxnet_input_loader.sv
// Streams a Maxnet frame (N activations then N*N weights) into flat buses, pulses start,
// waits for the datapath to converge (or time out) and holds the result until accepted.

module maxnet_word_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst)    q <= '0;
    else if (we) q <= d;
  end
endmodule

module maxnet_input_loader #(
  parameter int DATA_W  = 32,
  parameter int N       = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [N*DATA_W-1:0]   x_flat,
  output logic [N*N*DATA_W-1:0] w_flat,
  output logic                  start,
  output logic                  busy,
  input  logic                  is_finished,
  input  logic [DATA_W-1:0]     res,
  output logic                  result_valid,
  output logic [DATA_W-1:0]     result_data,
  output logic                  result_err,
  output logic [15:0]           result_cycles,
  input  logic                  result_ready
);
  localparam int FRAME = N + N*N;
  localparam int CW    = (FRAME > 1) ? $clog2(FRAME) : 1;

  typedef enum logic [1:0] {ST_LOAD, ST_START, ST_WAIT, ST_HOLD} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
    logic [15:0]       cycles;
  } result_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  result_t     rslt, rslt_nxt;
  logic        start_q;
  logic        xfer;

  logic [FRAME-1:0]             slot_we;
  logic [FRAME-1:0][DATA_W-1:0] image;

  assign in_ready = (state == ST_LOAD) & rst;
  assign xfer     = in_valid & in_ready;

  // One register per frame slot; word c of the frame lands in slot c.
  for (genvar i = 0; i < FRAME; i++) begin : g_slot
    assign slot_we[i] = xfer & (cnt == CW'(i));
    maxnet_word_reg #(.DATA_W(DATA_W)) u_slot (
      .clk (clk),
      .rst (rst),
      .we  (slot_we[i]),
      .d   (in_data),
      .q   (image[i])
    );
  end

  assign x_flat = image[N-1:0];
  assign w_flat = image[FRAME-1:N];

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    wait_cnt_nxt = wait_cnt;
    rslt_nxt     = rslt;
    case (state)
      ST_LOAD: begin
        if (xfer) begin
          if (cnt == CW'(FRAME-1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_START;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      ST_START: begin
        wait_cnt_nxt = '0;
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        // A finish seen on the last permitted cycle still counts as a success.
        if ((wait_cnt >= 16'(SETTLE)) && is_finished) begin
          rslt_nxt  = '{data: res, err: 1'b0, cycles: wait_cnt};
          state_nxt = ST_HOLD;
        end else if (wait_cnt == 16'(TIMEOUT-1)) begin
          rslt_nxt  = '{data: '0, err: 1'b1, cycles: 16'(TIMEOUT-1)};
          state_nxt = ST_HOLD;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      ST_HOLD: begin
        if (result_ready) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_LOAD;
      cnt      <= '0;
      wait_cnt <= '0;
      rslt     <= '0;
      start_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      rslt     <= rslt_nxt;
      start_q  <= (state_nxt == ST_START);
    end
  end

  assign start         = start_q;
  assign busy          = (state == ST_START) || (state == ST_WAIT);
  assign result_valid  = (state == ST_HOLD);
  assign result_data   = rslt.data;
  assign result_err    = rslt.err;
  assign result_cycles = rslt.cycles;
endmodule
